// File: rtl/memory_control_if.sv
// memory_control_if: cache-side and RAM-side signals of the memory controller
interface memory_control_if #(
    parameter int ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [ADDR_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [ADDR_W-1:0] dstore;
    logic              dwait;
    logic [ADDR_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [ADDR_W-1:0] ramstore;
    logic [ADDR_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_control.sv
// memory_control: arbitrates icache/dcache requests onto a single-ported RAM
// with data priority and a bounded-starvation guarantee for instruction fetch.
module memory_control #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input logic CLK,
    input logic RST,
    memory_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;
    localparam logic [1:0] ACCESS = 2'd2;

    state_t     r_state;
    logic [3:0] r_starve;
    logic       w_dreq, w_acc, w_force_i;

    assign w_dreq    = bus.dREN | bus.dWEN;
    assign w_acc     = bus.ramstate == ACCESS;
    assign w_force_i = (STARVE_LIMIT != 0) && (r_starve == 4'(STARVE_LIMIT)) && bus.iREN;

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else
            case (r_state)
                IDLE:
                    if (w_dreq && !w_force_i) begin
                        r_state  <= DSERV;
                        r_starve <= bus.iREN ? r_starve + {3'b0, r_starve != 4'hf} : 4'd0;
                    end else if (bus.iREN) begin
                        r_state  <= ISERV;
                        r_starve <= '0;
                    end
                DSERV: if (w_acc || !w_dreq) r_state <= IDLE;
                ISERV: if (w_acc || !bus.iREN) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    // a dropped request (abort) never reports completion, even under ACCESS
    always_comb begin
        bus.ramWEN   = r_state == DSERV && bus.dWEN;
        bus.ramREN   = r_state == ISERV || (r_state == DSERV && bus.dREN && !bus.dWEN);
        bus.ramaddr  = r_state == DSERV ? bus.daddr : r_state == ISERV ? bus.iaddr : {ADDR_W{1'b0}};
        bus.ramstore = r_state == DSERV ? bus.dstore : {ADDR_W{1'b0}};
        bus.dwait    = !(r_state == DSERV && w_dreq && w_acc);
        bus.iwait    = !(r_state == ISERV && bus.iREN && w_acc);
    end
endmodule

// File: tb/tb_memory_control.sv
// tb_memory_control: directed scenarios plus random traffic, every cycle
// checked against a transaction-level model of grant ownership.
module tb_memory_control;
    localparam int SL = 2;
    localparam int AW = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_owner = 0;
    int   m_cnt = 0;
    int   ord[$];
    int   exp_ord[6] = '{1, 1, 2, 1, 1, 2};

    memory_control_if #(.ADDR_W(AW)) bus ();

    memory_control #(.STARVE_LIMIT(SL), .ADDR_W(AW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_check();
        logic dreq, acc;
        if (RST) begin
            m_owner = 0;
            m_cnt   = 0;
        end
        dreq = bus.dREN | bus.dWEN;
        acc  = bus.ramstate == 2'd2;
        check("dwait", 32'(bus.dwait), 32'(!(m_owner == 1 && dreq && acc)));
        check("iwait", 32'(bus.iwait), 32'(!(m_owner == 2 && bus.iREN && acc)));
        check("ramWEN", 32'(bus.ramWEN), 32'(m_owner == 1 && bus.dWEN));
        check("ramREN", 32'(bus.ramREN), 32'(m_owner == 2 || (m_owner == 1 && bus.dREN && !bus.dWEN)));
        check("ramaddr", bus.ramaddr, m_owner == 1 ? bus.daddr : m_owner == 2 ? bus.iaddr : 32'h0);
        check("ramstore", bus.ramstore, m_owner == 1 ? bus.dstore : 32'h0);
        check("iload", bus.iload, bus.ramload);
        check("dload", bus.dload, bus.ramload);
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic advance();
        logic dreq;
        @(posedge CLK);
        dreq = bus.dREN | bus.dWEN;
        if (RST) begin
            m_owner = 0;
            m_cnt   = 0;
        end else if (m_owner == 0) begin
            if (dreq && !(SL != 0 && m_cnt == SL && bus.iREN)) begin
                m_owner = 1;
                m_cnt   = bus.iREN ? (m_cnt < 15 ? m_cnt + 1 : 15) : 0;
            end else if (bus.iREN) begin
                m_owner = 2;
                m_cnt   = 0;
            end
        end else if (m_owner == 1) begin
            if (!dreq || bus.ramstate == 2'd2) m_owner = 0;
        end else if (!bus.iREN || bus.ramstate == 2'd2) m_owner = 0;
        @(negedge CLK);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        bus.iREN     = 0;
        bus.iaddr    = 0;
        bus.dREN     = 0;
        bus.dWEN     = 0;
        bus.daddr    = 0;
        bus.dstore   = 0;
        bus.ramload  = 0;
        bus.ramstate = 2'd0;
    endtask

    task automatic do_reset();
        RST = 1;
        idle_inputs();
        tick();
        tick();
        RST = 0;
    endtask

    initial begin
        idle_inputs();
        @(negedge CLK);
        do_reset();

        // async reset mid-write drops the strobe immediately
        bus.dWEN = 1; bus.daddr = 32'h5; bus.dstore = 32'h9; bus.ramstate = 2'd1;
        tick();
        settle();
        check("pre_rst_wen", 32'(bus.ramWEN), 32'd1);
        #2 RST = 1;
        #1;
        model_check();
        check("rst_wen", 32'(bus.ramWEN), 32'd0);
        advance();
        tick();
        RST = 0; bus.dWEN = 0; bus.ramstate = 2'd0;
        settle();
        check("rst_iwait", 32'(bus.iwait), 32'd1);
        check("rst_dwait", 32'(bus.dwait), 32'd1);
        advance();

        // lone dcache read completing on its second service cycle
        bus.dREN = 1; bus.daddr = 32'h40; bus.ramstate = 2'd1;
        tick();
        tick();
        bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
        settle();
        check("rd_dwait", 32'(bus.dwait), 32'd0);
        check("rd_dload", bus.dload, 32'hDEADBEEF);
        check("rd_addr", bus.ramaddr, 32'h40);
        advance();
        bus.dREN = 0; bus.ramstate = 2'd0;
        settle();
        check("rd_turn", 32'(bus.dwait), 32'd1);
        advance();

        // simultaneous requests: data first, icache after the turnaround
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h1200; bus.dWEN = 1; bus.daddr = 32'h3100; bus.dstore = 32'h7;
        bus.ramstate = 2'd2;
        tick();
        settle();
        check("sim_wen", 32'(bus.ramWEN), 32'd1);
        check("sim_addr", bus.ramaddr, 32'h3100);
        check("sim_store", bus.ramstore, 32'h7);
        check("sim_iwait", 32'(bus.iwait), 32'd1);
        advance();
        bus.dWEN = 0;
        settle();
        check("sim_turn", 32'(bus.ramREN), 32'd0);
        advance();
        settle();
        check("sim_iaddr", bus.ramaddr, 32'h1200);
        check("sim_igrant", 32'(bus.iwait), 32'd0);
        advance();

        // starvation: iREN held, data always pending
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h88; bus.dREN = 1; bus.daddr = 32'h44; bus.ramstate = 2'd2;
        for (int i = 0; i < 12; i++) begin
            settle();
            if (!bus.dwait) ord.push_back(1);
            if (!bus.iwait) ord.push_back(2);
            advance();
        end
        check("ord_len", 32'(ord.size()), 32'd6);
        for (int k = 0; k < 6 && k < ord.size(); k++) check("ord", 32'(ord[k]), 32'(exp_ord[k]));

        // write wins over read, then abort under BUSY
        do_reset();
        bus.dREN = 1; bus.dWEN = 1; bus.ramstate = 2'd1;
        tick();
        settle();
        check("wr_wen", 32'(bus.ramWEN), 32'd1);
        check("wr_ren", 32'(bus.ramREN), 32'd0);
        advance();
        bus.dREN = 0; bus.dWEN = 0;
        settle();
        check("ab_wen", 32'(bus.ramWEN), 32'd0);
        check("ab_dwait", 32'(bus.dwait), 32'd1);
        advance();
        bus.dREN = 1;
        settle();
        check("ab_idle", 32'(bus.ramREN), 32'd0);
        advance();
        bus.dREN = 0; bus.ramstate = 2'd0;
        tick();

        // ERROR holds the instruction fetch until ACCESS
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h80; bus.ramstate = 2'd3;
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("err_iwait", 32'(bus.iwait), 32'd1);
            check("err_ren", 32'(bus.ramREN), 32'd1);
            advance();
        end
        bus.ramstate = 2'd2; bus.ramload = 32'hCAFE0001;
        settle();
        check("err_done", 32'(bus.iwait), 32'd0);
        check("err_iload", bus.iload, 32'hCAFE0001);
        advance();
        bus.iREN = 0; bus.ramstate = 2'd0;
        settle();
        check("err_after", 32'(bus.iwait), 32'd1);
        advance();

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            RST          = $urandom_range(99) == 0;
            bus.iREN     = $urandom_range(3) != 0;
            bus.dREN     = $urandom_range(2) == 0;
            bus.dWEN     = $urandom_range(3) == 0;
            bus.iaddr    = $urandom;
            bus.daddr    = $urandom;
            bus.dstore   = $urandom;
            bus.ramload  = $urandom;
            bus.ramstate = 2'($urandom_range(3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_control.md
Name: memory_control

Overview:
- Memory-side responder for the cache bus.
- Accepts instruction-fetch requests from the icache and read/write requests from the dcache.
- Arbitrates between the two, drives a single-ported RAM, and returns data with per-requester wait handshakes.
- Sits between the caches and the RAM model. It is the counterpart that answers the dcache fill, writeback, flush and hit-count traffic.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while iREN is pending before one instruction grant is forced. 0 disables fairness (pure data priority). Legal range 0..15.
- ADDR_W, 32: address and data width in bits.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache word address.
- iwait  out  1  low for exactly the cycle the icache read completes.
- iload  out  ADDR_W  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache word address.
- dstore  in  ADDR_W  dcache write data.
- dwait  out  1  low for exactly the cycle the dcache access completes.
- dload  out  ADDR_W  dcache read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  ADDR_W  RAM write data.
- ramload  in  ADDR_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Registered state: state ∈ {IDLE, DSERV, ISERV}, starve_cnt[3:0].
- All outputs are combinational from state and inputs.
- Reset (async, any cycle, including mid-access):
  - state=IDLE, starve_cnt=0.
  - Outputs while IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1.
  - Any RAM strobe drops in the same cycle RST rises.
- iload and dload always equal ramload. Consumers sample only when their wait is low.
- Define dreq = dREN|dWEN and force_i = (STARVE_LIMIT!=0) && (starve_cnt==STARVE_LIMIT) && iREN.
- IDLE:
  - dreq && !force_i → DSERV; starve_cnt = sat_inc(starve_cnt) if iREN, else 0.
  - Otherwise iREN → ISERV; starve_cnt=0.
  - Otherwise stay in IDLE.
  - No RAM strobes are driven in IDLE.
- DSERV:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&&!dWEN (write wins if both are asserted).
  - dwait = (ramstate!=ACCESS).
  - On ACCESS → IDLE.
  - If dREN=dWEN=0 before ACCESS (abort) → IDLE with strobes low that cycle; dwait stays 1.
- ISERV:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - iwait = (ramstate!=ACCESS).
  - On ACCESS → IDLE.
  - iREN=0 before ACCESS → abort to IDLE.
- The non-granted requester's wait stays 1 throughout.
- Every completed access is followed by one mandatory IDLE turnaround cycle. Minimum latency from request to wait-low is 2 cycles (IDLE → xSERV with ACCESS in the first xSERV cycle).
- ramstate BUSY or ERROR: the access holds, strobes stay asserted, wait stays 1. There is no timeout.
- Requester address or data changing mid-service passes straight through to the RAM. Requesters must hold them stable.
- starve_cnt saturates at 15 and never wraps.

Test Plan:
- Reset then idle: RST=1 mid-DSERV with ramWEN=1 → ramWEN=0 the same cycle; after release state=IDLE, iwait=dwait=1.
- Lone dcache read: dREN=1, daddr=0x40; ramstate=ACCESS on the 2nd service cycle with ramload=0xDEADBEEF → dwait low for exactly 1 cycle, dload=0xDEADBEEF, then one IDLE cycle.
- Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x3100, dstore=7) asserted together → data served first (ramWEN=1, ramaddr=0x3100, ramstore=7); icache granted after the turnaround cycle.
- Starvation: STARVE_LIMIT=2, iREN held high, dREN reasserted after every completion → grant order D, D, I, D, D, I.
- Write-over-read and abort: dREN=dWEN=1 → ramWEN=1, ramREN=0. Dropping both under BUSY → next state IDLE, dwait never low.
- ERROR hold: ramstate=3 for 5 cycles then 2 during ISERV → iwait stays 1 for 5 cycles, then low once.
